ls_operand_fetch: RTL and testbench

LS_OPERAND_FETCH -- requirements
Module: ls_operand_fetch

---
 rtl/ls_operand_fetch.sv | 161 ++++++++++++++++
 tb/tb_ls_operand_fetch.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_operand_fetch.sv
// ls_operand_fetch: register file read, RAW hazard scoreboard and operand
// latch between decode and the load/store stage.
//   clk, reset             : clock, asynchronous active-high reset
//   valid_in .. reg_write_in : decoded instruction fields (held while stall=1)
//   branch_taken           : flush the instruction on the inputs
//   wb_data/wb_addr/wb_en  : writeback port into the register file
//   op .. reg_write        : registered instruction fields
//   ra, rb, rt_st          : registered (bypassed) operand values
//   stall                  : combinational hold request to upstream
module ls_operand_fetch #(
  parameter int unsigned LAT = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_in,
  input  logic [0:10]   op_in,
  input  logic [2:0]    format_in,
  input  logic [0:6]    ra_addr,
  input  logic [0:6]    rb_addr,
  input  logic [0:6]    rt_addr_in,
  input  logic [0:17]   imm_in,
  input  logic          reg_write_in,
  input  logic          branch_taken,
  input  logic [0:127]  wb_data,
  input  logic [0:6]    wb_addr,
  input  logic          wb_en,
  output logic [0:10]   op,
  output logic [2:0]    format,
  output logic [0:6]    rt_addr,
  output logic [0:17]   imm,
  output logic          reg_write,
  output logic [0:127]  ra,
  output logic [0:127]  rb,
  output logic [0:127]  rt_st,
  output logic          stall
);

  localparam int unsigned NREG = 128;
  localparam int unsigned AW   = 7;
  localparam int unsigned DW   = 128;
  localparam int unsigned CW   = 3;
  localparam int unsigned OPW  = 11;
  localparam int unsigned IMMW = 18;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

  logic [0:DW-1]   r_rf  [NREG];
  logic [CW-1:0]   r_cnt [NREG];

  logic [0:OPW-1]  r_op;
  logic [2:0]      r_format;
  logic [0:AW-1]   r_rt_addr;
  logic [0:IMMW-1] r_imm;
  logic            r_reg_write;
  logic [0:DW-1]   r_ra;
  logic [0:DW-1]   r_rb;
  logic [0:DW-1]   r_rt_st;

  logic            w_ra_byp, w_rb_byp, w_rt_byp;
  logic [0:DW-1]   w_ra_val, w_rb_val, w_rt_val;
  logic            w_store;
  logic            w_use_ra, w_use_rb, w_use_rt;
  logic            w_ra_busy, w_rb_busy, w_rt_busy;
  logic            w_hazard;
  logic            w_issue;
  logic            w_cnt_load;

  // Same-cycle writeback bypass on all three read ports
  assign w_ra_byp = wb_en && (wb_addr == ra_addr);
  assign w_rb_byp = wb_en && (wb_addr == rb_addr);
  assign w_rt_byp = wb_en && (wb_addr == rt_addr_in);
  assign w_ra_val = w_ra_byp ? wb_data : r_rf[ra_addr];
  assign w_rb_val = w_rb_byp ? wb_data : r_rf[rb_addr];
  assign w_rt_val = w_rt_byp ? wb_data : r_rf[rt_addr_in];

  // Store opcodes: stqx (RR), stqd (RI10), stqa (RI16)
  assign w_store = ((format_in == 3'd0) && (op_in == 11'b00101000100)) ||
                   ((format_in == 3'd4) && (op_in[3:10] == 8'b00100100)) ||
                   ((format_in == 3'd5) && (op_in[2:10] == 9'b001000001));

  assign w_use_ra = (format_in == 3'd0) || (format_in == 3'd4);
  assign w_use_rb = (format_in == 3'd0);
  assign w_use_rt = w_store;

  // A pending register whose value is arriving on the writeback port this cycle is not a hazard
  assign w_ra_busy = (r_cnt[ra_addr]    != '0) && !w_ra_byp;
  assign w_rb_busy = (r_cnt[rb_addr]    != '0) && !w_rb_byp;
  assign w_rt_busy = (r_cnt[rt_addr_in] != '0) && !w_rt_byp;

  assign w_hazard   = (w_use_ra && w_ra_busy) || (w_use_rb && w_rb_busy) ||
                      (w_use_rt && w_rt_busy);
  assign w_issue    = valid_in && !branch_taken && !w_hazard;
  assign w_cnt_load = w_issue && reg_write_in && !w_store;

  assign stall = !reset && valid_in && !branch_taken && w_hazard;

  // Register file write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (wb_en) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  // Pending-result scoreboard; a new load reloads even a busy counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_cnt_load && (rt_addr_in == AW'(i))) begin
          r_cnt[i] <= CNT_LOAD;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - CW'(1);
        end
      end
    end
  end

  // Output latch: issued instruction or NOP bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op        <= '0;
      r_format    <= '0;
      r_rt_addr   <= '0;
      r_imm       <= '0;
      r_reg_write <= 1'b0;
      r_ra        <= '0;
      r_rb        <= '0;
      r_rt_st     <= '0;
    end else if (w_issue) begin
      r_op        <= op_in;
      r_format    <= format_in;
      r_rt_addr   <= rt_addr_in;
      r_imm       <= imm_in;
      r_reg_write <= reg_write_in;
      r_ra        <= w_ra_val;
      r_rb        <= w_rb_val;
      r_rt_st     <= w_rt_val;
    end else begin
      r_op        <= '0;
      r_format    <= '0;
      r_rt_addr   <= '0;
      r_imm       <= '0;
      r_reg_write <= 1'b0;
      r_ra        <= '0;
      r_rb        <= '0;
      r_rt_st     <= '0;
    end
  end

  assign op        = r_op;
  assign format    = r_format;
  assign rt_addr   = r_rt_addr;
  assign imm       = r_imm;
  assign reg_write = r_reg_write;
  assign ra        = r_ra;
  assign rb        = r_rb;
  assign rt_st     = r_rt_st;

endmodule

// File: tb/tb_ls_operand_fetch.sv
// Directed bench for ls_operand_fetch: bypass, RAW stall timing, store rt
// hazard, branch flush and asynchronous reset during a stall.
module tb_ls_operand_fetch;

  localparam int unsigned LAT = 6;

  localparam logic [0:10] OP_LQX  = 11'b00111000100;
  localparam logic [0:10] OP_LQD  = 11'b00000110100;
  localparam logic [0:10] OP_STQA = 11'b00001000001;

  localparam logic [0:127] D_AA = {32{4'hA}};
  localparam logic [0:127] D_B9 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [0:127] D_C0 = 128'hC0C0_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [0:127] D_D3 = 128'hD3D3_D3D3_0000_0000_DDDD_DDDD_3333_3333;
  localparam logic [0:127] D_E3 = 128'hE3E3_0001_0002_0003_0004_0005_0006_0007;

  logic          clk;
  logic          reset;
  logic          valid_in;
  logic [0:10]   op_in;
  logic [2:0]    format_in;
  logic [0:6]    ra_addr, rb_addr, rt_addr_in;
  logic [0:17]   imm_in;
  logic          reg_write_in;
  logic          branch_taken;
  logic [0:127]  wb_data;
  logic [0:6]    wb_addr;
  logic          wb_en;
  logic [0:10]   op;
  logic [2:0]    format;
  logic [0:6]    rt_addr;
  logic [0:17]   imm;
  logic          reg_write;
  logic [0:127]  ra, rb, rt_st;
  logic          stall;

  int n_cmp;
  int n_err;

  ls_operand_fetch #(.LAT(LAT)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .op_in(op_in),
    .format_in(format_in), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .rt_addr_in(rt_addr_in), .imm_in(imm_in), .reg_write_in(reg_write_in),
    .branch_taken(branch_taken), .wb_data(wb_data), .wb_addr(wb_addr),
    .wb_en(wb_en), .op(op), .format(format), .rt_addr(rt_addr), .imm(imm),
    .reg_write(reg_write), .ra(ra), .rb(rb), .rt_st(rt_st), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_idle();
    valid_in = 1'b0; op_in = '0; format_in = '0; ra_addr = '0; rb_addr = '0;
    rt_addr_in = '0; imm_in = '0; reg_write_in = 1'b0; branch_taken = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic drive_insn(input logic [0:10] o, input logic [2:0] f,
                            input logic [0:6] a, input logic [0:6] b,
                            input logic [0:6] t, input logic [0:17] i,
                            input logic rw);
    valid_in = 1'b1; op_in = o; format_in = f; ra_addr = a; rb_addr = b;
    rt_addr_in = t; imm_in = i; reg_write_in = rw;
  endtask

  task automatic drive_wb(input logic [0:6] a, input logic [0:127] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, "_op"}, 128'(op), 128'd0);
    chk({tag, "_rw"}, 128'(reg_write), 128'd0);
    chk({tag, "_ra"}, 128'(ra), 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    drive_idle();
    reset = 1'b0;
    #1 reset = 1'b1;
    drive_insn(OP_LQX, 3'd0, 7'd1, 7'd2, 7'd3, 18'd0, 1'b1);
    #2;
    chk("rst_op", 128'(op), 128'd0);
    chk("rst_ra", 128'(ra), 128'd0);
    chk("rst_stall", 128'(stall), 128'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    drive_idle();
    tick();

    // Writeback then read the following cycle
    drive_wb(7'd5, D_AA);
    tick();
    drive_idle();
    drive_insn(OP_LQX, 3'd0, 7'd5, 7'd5, 7'd10, 18'd0, 1'b1);
    settle();
    chk("rf_stall", 128'(stall), 128'd0);
    tick();
    chk("rf_op", 128'(op), 128'(OP_LQX));
    chk("rf_ra", 128'(ra), 128'(D_AA));
    chk("rf_rb", 128'(rb), 128'(D_AA));
    chk("rf_rt", 128'(rt_addr), 128'd10);
    chk("rf_rw", 128'(reg_write), 128'd1);

    // Same-cycle bypass on lqd
    drive_insn(OP_LQD, 3'd4, 7'd9, 7'd0, 7'd11, 18'h155, 1'b1);
    drive_wb(7'd9, D_B9);
    settle();
    chk("byp_stall", 128'(stall), 128'd0);
    tick();
    chk("byp_ra", 128'(ra), 128'(D_B9));
    chk("byp_imm", 128'(imm), 128'h155);
    chk("byp_fmt", 128'(format), 128'd4);

    // Bypass of a still-pending register suppresses the hazard
    drive_insn(OP_LQX, 3'd0, 7'd10, 7'd9, 7'd12, 18'd0, 1'b1);
    drive_wb(7'd10, D_C0);
    settle();
    chk("pbyp_stall", 128'(stall), 128'd0);
    tick();
    chk("pbyp_ra", 128'(ra), 128'(D_C0));
    chk("pbyp_rb", 128'(rb), 128'(D_B9));

    drive_idle();
    drive_wb(7'd3, D_D3);
    tick();
    drive_idle();
    repeat (7) tick();
    chk_nop("idle");

    // RAW: lqd rt=3 then lqx ra=3 stalls LAT-1 cycles
    drive_insn(OP_LQD, 3'd4, 7'd1, 7'd0, 7'd3, 18'd7, 1'b1);
    settle();
    chk("raw_ld_stall", 128'(stall), 128'd0);
    tick();
    chk("raw_ld_rt", 128'(rt_addr), 128'd3);
    drive_insn(OP_LQX, 3'd0, 7'd3, 7'd2, 7'd4, 18'd0, 1'b1);
    for (int i = 0; i < int'(LAT) - 1; i++) begin
      settle();
      chk($sformatf("raw_stall%0d", i), 128'(stall), 128'd1);
      tick();
      chk_nop($sformatf("raw_nop%0d", i));
    end
    settle();
    chk("raw_free", 128'(stall), 128'd0);
    tick();
    chk("raw_op", 128'(op), 128'(OP_LQX));
    chk("raw_ra", 128'(ra), 128'(D_D3));
    chk("raw_rt", 128'(rt_addr), 128'd4);

    drive_idle();
    repeat (6) tick();

    // Store rt hazard; writeback to a pending register does not clear it
    drive_insn(OP_LQD, 3'd4, 7'd1, 7'd0, 7'd3, 18'd0, 1'b1);
    tick();
    drive_idle();
    drive_wb(7'd3, D_E3);
    tick();
    drive_idle();
    drive_insn(OP_STQA, 3'd5, 7'd0, 7'd0, 7'd3, 18'h2A, 1'b1);
    for (int i = 0; i < int'(LAT) - 2; i++) begin
      settle();
      chk($sformatf("st_stall%0d", i), 128'(stall), 128'd1);
      tick();
    end
    settle();
    chk("st_free", 128'(stall), 128'd0);
    tick();
    chk("st_op", 128'(op), 128'(OP_STQA));
    chk("st_fmt", 128'(format), 128'd5);
    chk("st_rtst", 128'(rt_st), 128'(D_E3));
    chk("st_imm", 128'(imm), 128'h2A);
    drive_insn(OP_LQX, 3'd0, 7'd3, 7'd3, 7'd13, 18'd0, 1'b1);
    settle();
    chk("st_nocnt", 128'(stall), 128'd0);
    tick();
    chk("st_rd_ra", 128'(ra), 128'(D_E3));

    drive_idle();
    repeat (6) tick();

    // Branch flush
    drive_insn(OP_LQX, 3'd0, 7'd20, 7'd21, 7'd22, 18'd0, 1'b1);
    branch_taken = 1'b1;
    settle();
    chk("br_stall", 128'(stall), 128'd0);
    tick();
    chk_nop("br");
    branch_taken = 1'b0;
    drive_insn(OP_LQX, 3'd0, 7'd22, 7'd22, 7'd23, 18'd0, 1'b1);
    settle();
    chk("br_nocnt", 128'(stall), 128'd0);
    tick();
    chk("br_next_op", 128'(op), 128'(OP_LQX));
    drive_insn(OP_LQX, 3'd0, 7'd23, 7'd0, 7'd24, 18'd0, 1'b1);
    branch_taken = 1'b1;
    settle();
    chk("br_haz_stall", 128'(stall), 128'd0);
    tick();
    chk_nop("br_haz");
    branch_taken = 1'b0;

    // Reset during a stall
    drive_idle();
    drive_insn(OP_LQD, 3'd4, 7'd1, 7'd0, 7'd30, 18'h3FF, 1'b1);
    tick();
    chk("rs_pre_imm", 128'(imm), 128'h3FF);
    drive_insn(OP_LQX, 3'd0, 7'd30, 7'd5, 7'd31, 18'd0, 1'b1);
    settle();
    chk("rs_pre_stall", 128'(stall), 128'd1);
    reset = 1'b1;
    #1;
    chk("rs_op", 128'(op), 128'd0);
    chk("rs_imm", 128'(imm), 128'd0);
    chk("rs_rt", 128'(rt_addr), 128'd0);
    chk("rs_rw", 128'(reg_write), 128'd0);
    chk("rs_stall", 128'(stall), 128'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rs_post_stall", 128'(stall), 128'd0);
    tick();
    chk("rs_post_op", 128'(op), 128'(OP_LQX));
    chk("rs_post_rb", 128'(rb), 128'd0);
    chk("rs_post_rt", 128'(rt_addr), 128'd31);

    drive_idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
